// File: rtl/rec_read_seq_pkg.sv
// Shared definitions for the CAN receive-register read sequencer: state
// encoding, read-address table and default hold timeout.
package rec_read_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_DRAIN = 3'd2,
        ST_HOLD  = 3'd3,
        ST_CLR   = 3'd4,
        ST_GAP   = 3'd5
    } state_t;

    localparam int IDX_W  = 3;
    localparam int RD_LEN = 5;
    localparam logic [IDX_W-1:0] RD_LAST = 3'd4;
    localparam logic [15:0] HOLD_TIMEOUT_DEFAULT = 16'd1000;

    // Receive registers are fetched highest address first.
    localparam logic [4:0] RD_ADDR_TABLE [RD_LEN] = '{5'h5, 5'h3, 5'h2, 5'h1, 5'h0};

    function automatic logic [4:0] rd_addr(input logic [IDX_W-1:0] idx);
        return RD_ADDR_TABLE[idx];
    endfunction

endpackage

// File: rtl/rec_read_seq_if.sv
// Handshake bundle between the read sequencer and its CAN controller,
// receive buffer and downstream message consumer.
interface rec_read_seq_if;
    logic        irq_rec;
    logic [4:0]  bus_sel;
    logic [4:0]  reg_addr;
    logic        reg_rd;
    logic [4:0]  buf_addr;
    logic        buffer_en;
    logic [4:0]  can_rec_select;
    logic        msg_valid;
    logic        msg_ready;
    logic        irq_clr;
    logic        timeout_err;
    logic [15:0] msg_count;

    modport master (
        input  irq_rec, bus_sel, msg_ready,
        output reg_addr, reg_rd, buf_addr, buffer_en, can_rec_select,
               msg_valid, irq_clr, timeout_err, msg_count
    );

    modport slave (
        output irq_rec, bus_sel, msg_ready,
        input  reg_addr, reg_rd, buf_addr, buffer_en, can_rec_select,
               msg_valid, irq_clr, timeout_err, msg_count
    );
endinterface

// File: rtl/rec_read_seq.sv
// Reads the five receive registers of the selected CAN controller on an
// interrupt, offers the message downstream, then clears the interrupt.
module rec_read_seq
    import rec_read_seq_pkg::*;
#(
    parameter logic [15:0] HOLD_TIMEOUT = HOLD_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    rec_read_seq_if.master bus
);

    state_t           state_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [15:0]      hold_cnt_reg;
    logic [4:0]       reg_addr_reg;
    logic             reg_rd_reg;
    logic [4:0]       buf_addr_reg;
    logic             buffer_en_reg;
    logic [4:0]       sel_reg;
    logic             msg_valid_reg;
    logic             irq_clr_reg;
    logic [15:0]      msg_count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            idx_reg       <= '0;
            hold_cnt_reg  <= '0;
            reg_addr_reg  <= '0;
            reg_rd_reg    <= 1'b0;
            buf_addr_reg  <= '0;
            buffer_en_reg <= 1'b0;
            sel_reg       <= '0;
            msg_valid_reg <= 1'b0;
            irq_clr_reg   <= 1'b0;
            msg_count_reg <= '0;
        end else begin
            // Controller returns data one cycle after the strobe; the buffer
            // controls follow the read controls with the same delay.
            buf_addr_reg  <= reg_addr_reg;
            buffer_en_reg <= reg_rd_reg;
            irq_clr_reg   <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (bus.irq_rec) begin
                        state_reg    <= ST_RD;
                        idx_reg      <= '0;
                        sel_reg      <= bus.bus_sel;
                        reg_addr_reg <= rd_addr('0);
                        reg_rd_reg   <= 1'b1;
                    end
                end
                ST_RD: begin
                    if (idx_reg == RD_LAST) begin
                        state_reg    <= ST_DRAIN;
                        reg_addr_reg <= '0;
                        reg_rd_reg   <= 1'b0;
                    end else begin
                        idx_reg      <= idx_reg + 3'd1;
                        reg_addr_reg <= rd_addr(idx_reg + 3'd1);
                    end
                end
                ST_DRAIN: begin
                    state_reg     <= ST_HOLD;
                    hold_cnt_reg  <= '0;
                    msg_valid_reg <= 1'b1;
                end
                ST_HOLD: begin
                    // Acceptance is checked first so a late msg_ready still wins.
                    if (bus.msg_ready) begin
                        state_reg     <= ST_CLR;
                        msg_valid_reg <= 1'b0;
                        irq_clr_reg   <= 1'b1;
                        msg_count_reg <= msg_count_reg + 16'd1;
                    end else if (hold_cnt_reg == HOLD_TIMEOUT - 16'd1) begin
                        state_reg     <= ST_CLR;
                        msg_valid_reg <= 1'b0;
                        irq_clr_reg   <= 1'b1;
                    end else begin
                        hold_cnt_reg  <= hold_cnt_reg + 16'd1;
                    end
                end
                ST_CLR: state_reg <= ST_GAP;
                ST_GAP: state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.reg_addr       = reg_addr_reg;
    assign bus.reg_rd         = reg_rd_reg;
    assign bus.buf_addr       = buf_addr_reg;
    assign bus.buffer_en      = buffer_en_reg;
    assign bus.can_rec_select = sel_reg;
    assign bus.msg_valid      = msg_valid_reg;
    assign bus.irq_clr        = irq_clr_reg;
    assign bus.msg_count      = msg_count_reg;

    // Flags the drop in the last HOLD cycle itself, so irq_clr follows it.
    assign bus.timeout_err = msg_valid_reg && !bus.msg_ready &&
                             (hold_cnt_reg == HOLD_TIMEOUT - 16'd1);

endmodule

// File: tb/tb_rec_read_seq.sv
// Self-checking bench for rec_read_seq: a vector table, hand-written corner
// sequences and randomized traffic checked against a sequence-position model.
module tb_rec_read_seq;

    localparam int T = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rec_read_seq_if bus();

    rec_read_seq #(.HOLD_TIMEOUT(16'd4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: m_pos is the cycle position within a sequence
    // (0 idle, 1-5 reads, 6 drain, 7 hold, 8 clear, 9 gap).
    int          m_pos = 0;
    int          m_wait = 0;
    logic [4:0]  m_sel = '0;
    logic [4:0]  m_ba = '0;
    logic        m_be = 1'b0;
    logic [15:0] m_cnt = '0;
    logic [4:0]  addr_tab [5] = '{5'd5, 5'd3, 5'd2, 5'd1, 5'd0};

    function automatic logic [4:0] m_addr();
        return (m_pos >= 1 && m_pos <= 5) ? addr_tab[m_pos-1] : 5'd0;
    endfunction

    function automatic logic m_rd();
        return (m_pos >= 1 && m_pos <= 5);
    endfunction

    task automatic model_step();
        logic [4:0] a;
        logic       r;
        a = m_addr();
        r = m_rd();
        if (rst) begin
            m_pos = 0; m_wait = 0; m_sel = '0; m_ba = '0; m_be = 1'b0; m_cnt = '0;
        end else begin
            m_ba = a;
            m_be = r;
            if (m_pos == 0) begin
                if (bus.irq_rec) begin
                    m_pos = 1;
                    m_sel = bus.bus_sel;
                end
            end else if (m_pos == 6) begin
                m_pos = 7;
                m_wait = 0;
            end else if (m_pos == 7) begin
                if (bus.msg_ready) begin
                    m_cnt = m_cnt + 16'd1;
                    m_pos = 8;
                end else if (m_wait == T - 1) begin
                    m_pos = 8;
                end else begin
                    m_wait++;
                end
            end else if (m_pos == 9) begin
                m_pos = 0;
            end else begin
                m_pos++;
            end
        end
    endtask

    task automatic check_model();
        chk("reg_addr", 32'(bus.reg_addr), 32'(m_addr()));
        chk("reg_rd", 32'(bus.reg_rd), 32'(m_rd()));
        chk("buf_addr", 32'(bus.buf_addr), 32'(m_ba));
        chk("buffer_en", 32'(bus.buffer_en), 32'(m_be));
        chk("can_rec_select", 32'(bus.can_rec_select), 32'(m_sel));
        chk("msg_valid", 32'(bus.msg_valid), 32'(m_pos == 7));
        chk("irq_clr", 32'(bus.irq_clr), 32'(m_pos == 8));
        chk("timeout_err", 32'(bus.timeout_err),
            32'(m_pos == 7 && m_wait == T - 1 && !bus.msg_ready));
        chk("msg_count", 32'(bus.msg_count), 32'(m_cnt));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model();
    endtask

    typedef struct {
        logic        irq;
        logic        ready;
        logic [4:0]  addr;
        logic        rd;
        logic [4:0]  ba;
        logic        be;
        logic        valid;
        logic        clr;
        logic [15:0] cnt;
        logic [4:0]  sel;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int nvalid, nto, starts, last_start, cyc, cnt0;
        logic prev_to, seen;

        // One full sequence with msg_ready tied high, bus_sel 9.
        vecs[0] = '{1'b1, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 16'd0, 5'd9};
        vecs[1] = '{1'b0, 1'b1, 5'd3, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 16'd0, 5'd9};
        vecs[2] = '{1'b0, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 16'd0, 5'd9};
        vecs[3] = '{1'b0, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 16'd0, 5'd9};
        vecs[4] = '{1'b0, 1'b1, 5'd0, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 16'd0, 5'd9};
        vecs[5] = '{1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 16'd0, 5'd9};
        vecs[6] = '{1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 16'd0, 5'd9};
        vecs[7] = '{1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 16'd1, 5'd9};
        vecs[8] = '{1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 16'd1, 5'd9};
        vecs[9] = '{1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 16'd1, 5'd9};

        rst = 1'b1;
        bus.irq_rec = 1'b0;
        bus.bus_sel = 5'd0;
        bus.msg_ready = 1'b0;
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;
        tick();

        bus.bus_sel = 5'd9;
        for (int i = 0; i < 10; i++) begin
            bus.irq_rec = vecs[i].irq;
            bus.msg_ready = vecs[i].ready;
            tick();
            chk($sformatf("tbl%0d_addr", i), 32'(bus.reg_addr), 32'(vecs[i].addr));
            chk($sformatf("tbl%0d_rd", i), 32'(bus.reg_rd), 32'(vecs[i].rd));
            chk($sformatf("tbl%0d_ba", i), 32'(bus.buf_addr), 32'(vecs[i].ba));
            chk($sformatf("tbl%0d_be", i), 32'(bus.buffer_en), 32'(vecs[i].be));
            chk($sformatf("tbl%0d_valid", i), 32'(bus.msg_valid), 32'(vecs[i].valid));
            chk($sformatf("tbl%0d_clr", i), 32'(bus.irq_clr), 32'(vecs[i].clr));
            chk($sformatf("tbl%0d_cnt", i), 32'(bus.msg_count), 32'(vecs[i].cnt));
            chk($sformatf("tbl%0d_sel", i), 32'(bus.can_rec_select), 32'(vecs[i].sel));
        end

        // bus_sel changes mid-read must not disturb the latched select.
        bus.bus_sel = 5'd7;
        bus.irq_rec = 1'b1;
        tick();
        bus.irq_rec = 1'b0;
        tick();
        bus.bus_sel = 5'd3;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("sel_hold", 32'(bus.can_rec_select), 32'd7);
        end

        // Timeout: no msg_ready at all.
        bus.msg_ready = 1'b0;
        bus.irq_rec = 1'b1;
        tick();
        bus.irq_rec = 1'b0;
        nvalid = 0; nto = 0; prev_to = 1'b0;
        cnt0 = int'(bus.msg_count);
        for (int i = 0; i < 15; i++) begin
            tick();
            if (prev_to) chk("clr_after_to", 32'(bus.irq_clr), 32'd1);
            if (bus.msg_valid) nvalid++;
            if (bus.timeout_err) nto++;
            prev_to = bus.timeout_err;
        end
        chk("to_valid_cycles", 32'(nvalid), 32'(T));
        chk("to_pulses", 32'(nto), 32'd1);
        chk("to_count_same", 32'(bus.msg_count), 32'(cnt0));

        // msg_ready arriving in the timeout cycle is accepted.
        bus.irq_rec = 1'b1;
        tick();
        bus.irq_rec = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            seen = bus.msg_valid;
        end
        chk("hold_reached", 32'(seen), 32'd1);
        for (int i = 0; i < T - 1; i++) tick();
        chk("to_pending", 32'(bus.timeout_err), 32'd1);
        bus.msg_ready = 1'b1;
        #1;
        chk("to_suppressed", 32'(bus.timeout_err), 32'd0);
        tick();
        chk("late_accept_clr", 32'(bus.irq_clr), 32'd1);
        chk("late_accept_cnt", 32'(bus.msg_count), 32'(cnt0 + 1));
        for (int i = 0; i < 3; i++) tick();

        // Back-to-back sequences with irq_rec held high.
        cnt0 = int'(bus.msg_count);
        bus.irq_rec = 1'b1;
        starts = 0; last_start = 0;
        for (cyc = 1; cyc <= 30; cyc++) begin
            tick();
            if (bus.reg_rd && bus.reg_addr == 5'd5) begin
                if (starts > 0) chk("b2b_period", 32'(cyc - last_start), 32'd10);
                starts++;
                last_start = cyc;
            end
        end
        bus.irq_rec = 1'b0;
        chk("b2b_starts", 32'(starts), 32'd3);
        chk("b2b_count", 32'(bus.msg_count), 32'(cnt0 + 3));
        tick();

        // Reset during read index 2, then restart with irq_rec still high.
        bus.irq_rec = 1'b1;
        tick(); tick(); tick();
        chk("rd_idx2_addr", 32'(bus.reg_addr), 32'd2);
        rst = 1'b1;
        tick();
        chk("rst_rd", 32'(bus.reg_rd), 32'd0);
        chk("rst_clr", 32'(bus.irq_clr), 32'd0);
        chk("rst_cnt", 32'(bus.msg_count), 32'd0);
        chk("rst_sel", 32'(bus.can_rec_select), 32'd0);
        rst = 1'b0;
        tick();
        chk("restart_rd", 32'(bus.reg_rd), 32'd1);
        chk("restart_addr", 32'(bus.reg_addr), 32'd5);
        bus.irq_rec = 1'b0;
        for (int i = 0; i < 10; i++) tick();

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            bus.irq_rec = ($urandom_range(0, 3) == 0);
            bus.msg_ready = ($urandom_range(0, 9) < 3);
            bus.bus_sel = 5'($urandom_range(0, 31));
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;
        bus.irq_rec = 1'b0;
        for (int i = 0; i < 12; i++) tick();

        // Counter wrap from a preset value.
        force dut.msg_count_reg = 16'hFFFF;
        #1;
        release dut.msg_count_reg;
        m_cnt = 16'hFFFF;
        chk("preset_cnt", 32'(bus.msg_count), 32'hFFFF);
        bus.msg_ready = 1'b1;
        bus.irq_rec = 1'b1;
        tick();
        bus.irq_rec = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        chk("wrap_cnt", 32'(bus.msg_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rec_read_seq.md
REC_READ_SEQ -- requirements
Module: rec_read_seq

Interface
REQ-001 Parameter HOLD_TIMEOUT, 16'd1000: max cycles msg_valid waits for msg_ready before the message is dropped.
REQ-002 Port clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port rst  input  1  reset; synchronous, active-high.
REQ-004 Port irq_rec  input  1  receive-interrupt level from CAN controller; high = message pending.
REQ-005 Port bus_sel  input  5  CAN bus ID of the controller currently serviced.
REQ-006 Port reg_addr  output  5  CAN controller receive-register read address.
REQ-007 Port reg_rd  output  1  read strobe; controller returns data_rec_in one cycle later.
REQ-008 Port buf_addr  output  5  register address aligned with returned data; drives buffer addr.
REQ-009 Port buffer_en  output  1  capture enable aligned with returned data; drives buffer buffer_en.
REQ-010 Port can_rec_select  output  5  bus_sel latched at sequence start; stable until return to IDLE.
REQ-011 Port msg_valid  output  1  complete 76-bit message present in buffer.
REQ-012 Port msg_ready  input  1  downstream accepts message.
REQ-013 Port irq_clr  output  1  one-cycle pulse clearing controller receive interrupt.
REQ-014 Port timeout_err  output  1  one-cycle pulse on message drop.
REQ-015 Port msg_count  output  16  accepted messages, wraps 16'hFFFF -> 0.

Function
REQ-016 FSM states IDLE, RD, DRAIN, HOLD, CLR, GAP; exactly one active.
REQ-017 IDLE -> RD when irq_rec=1; same edge latches bus_sel into can_rec_select, clears 3-bit read index.
REQ-018 RD lasts exactly 5 cycles; index 0..4 drives reg_addr 5'h5, 5'h3, 5'h2, 5'h1, 5'h0, reg_rd=1 each cycle.
REQ-019 RD (index 4) -> DRAIN; DRAIN lasts 1 cycle, reg_rd=0, reg_addr=0.
REQ-020 buf_addr and buffer_en are reg_addr and reg_rd registered by one cycle; buffer_en high exactly 5 consecutive cycles per sequence.
REQ-021 DRAIN -> HOLD; msg_valid=1 throughout HOLD, 0 elsewhere.
REQ-022 HOLD with msg_ready=1 -> CLR, msg_count increments by 1 on that edge.
REQ-023 HOLD timeout counter clears on HOLD entry, increments each HOLD cycle without msg_ready; at HOLD_TIMEOUT-1 -> CLR with timeout_err pulse, msg_count unchanged.
REQ-024 msg_ready arriving in the timeout cycle wins: accept, no timeout_err.
REQ-025 CLR lasts 1 cycle, irq_clr=1; CLR -> GAP.
REQ-026 GAP lasts 1 cycle, irq_rec ignored; GAP -> IDLE.
REQ-027 irq_rec changes outside IDLE are ignored; msg_ready outside HOLD is ignored.
REQ-028 Back-to-back: irq_rec still high in IDLE after GAP starts a new sequence; minimum period 10 cycles (IDLE+5 RD+DRAIN+HOLD+CLR+GAP).

Reset
REQ-029 rst=1 at an edge forces IDLE, all outputs 0 (reg_addr, buf_addr, can_rec_select 5'h0; msg_count 16'h0), counters 0, regardless of state.
REQ-030 Reset mid-sequence abandons the message without irq_clr; irq_rec still high restarts from RD after release.

Structure
REQ-031 Shared package: state encoding, read-address table {5'h5,5'h3,5'h2,5'h1,5'h0}, index width, default HOLD_TIMEOUT.
REQ-032 Single flat module; no sub-module; top level instantiates it beside buffer_rec_data sharing clk, data path untouched.

Verification
REQ-033 irq_rec=1 for 1 cycle, msg_ready tied 1 -> reg_addr 5,3,2,1,0 on cycles 1-5, buffer_en cycles 2-6, msg_valid cycle 7 only, irq_clr cycle 8, msg_count=1.
REQ-034 bus_sel=5'd7 at start, changed to 5'd3 mid-RD -> can_rec_select holds 7 until IDLE.
REQ-035 HOLD_TIMEOUT=4, msg_ready=0 -> msg_valid 4 cycles, timeout_err one pulse, irq_clr next cycle, msg_count=0.
REQ-036 irq_rec held high, msg_ready=1 -> new sequence every 10 cycles, 3 messages -> msg_count=3.
REQ-037 rst=1 during RD index 2 -> next cycle all outputs 0, no irq_clr, reg_rd=0.
REQ-038 msg_count preset to 16'hFFFF via 65535 accepted messages (or forced) -> next accept gives 16'h0000.
